// File: rtl/grayscale_sobel_edge.sv
// Streaming 3x3 Sobel edge detector on an 8-bit grayscale raster.
// Two row line buffers feed a sliding window; the magnitude is |Gx|+|Gy| saturated to 8 bits.
module grayscale_sobel_edge #(
    parameter int          IMG_WIDTH = 640,
    parameter logic [7:0]  THRESHOLD = 8'd64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] gray_in,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic [7:0] edge_mag,
    output logic       edge_bit,
    output logic       out_valid
);

    localparam int            CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ROW0, ROW1, STREAM} state_t;

    state_t        state, state_eff, state_nxt;
    logic [CW-1:0] col, col_eff, col_nxt;
    logic          take, qual;
    logic [2:1]    vld_pipe;

    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb2 [IMG_WIDTH];
    logic [7:0] rd1, rd2;
    logic [7:0] p [3][3];

    // An sof pixel restarts the frame in the same cycle it arrives.
    always_comb begin
        state_eff = state;
        col_eff   = col;
        take      = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                state_eff = ROW0;
                col_eff   = '0;
                take      = 1'b1;
            end else if (state != IDLE) begin
                take = 1'b1;
            end
        end
        state_nxt = state;
        col_nxt   = col;
        if (take) begin
            state_nxt = state_eff;
            if (col_eff == LAST) begin
                col_nxt = '0;
                case (state_eff)
                    ROW0:    state_nxt = ROW1;
                    ROW1:    state_nxt = STREAM;
                    default: state_nxt = state_eff;
                endcase
            end else begin
                col_nxt = col_eff + CW'(1);
            end
        end
    end

    assign qual = take && (state_eff == STREAM) && (col_eff >= CW'(2));
    assign rd1  = lb1[col_eff];
    assign rd2  = lb2[col_eff];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            vld_pipe <= '0;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            vld_pipe <= {vld_pipe[1], qual};
        end
    end

    // Storage carries no reset; the STREAM/column gating masks stale contents.
    always_ff @(posedge clk) begin
        if (take) begin
            lb1[col_eff] <= gray_in;
            lb2[col_eff] <= rd1;
            for (int i = 0; i < 3; i++) begin
                p[i][0] <= p[i][1];
                p[i][1] <= p[i][2];
            end
            p[0][2] <= rd2;
            p[1][2] <= rd1;
            p[2][2] <= gray_in;
        end
    end

    logic        [9:0]  gx_pos, gx_neg, gy_pos, gy_neg, ax, ay;
    logic signed [10:0] gx, gy;
    logic        [10:0] mag;
    logic        [7:0]  mag_sat;

    always_comb begin
        gx_pos  = {2'b0, p[0][2]} + {1'b0, p[1][2], 1'b0} + {2'b0, p[2][2]};
        gx_neg  = {2'b0, p[0][0]} + {1'b0, p[1][0], 1'b0} + {2'b0, p[2][0]};
        gy_pos  = {2'b0, p[2][0]} + {1'b0, p[2][1], 1'b0} + {2'b0, p[2][2]};
        gy_neg  = {2'b0, p[0][0]} + {1'b0, p[0][1], 1'b0} + {2'b0, p[0][2]};
        gx      = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy      = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
        ax      = gx[10] ? 10'(-gx) : gx[9:0];
        ay      = gy[10] ? 10'(-gy) : gy[9:0];
        mag     = {1'b0, ax} + {1'b0, ay};
        mag_sat = (|mag[10:8]) ? 8'hFF : mag[7:0];
    end

    // Outputs update only on a valid result and hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_mag <= 8'd0;
            edge_bit <= 1'b0;
        end else if (vld_pipe[1]) begin
            edge_mag <= mag_sat;
            edge_bit <= (mag_sat >= THRESHOLD);
        end
    end

    assign out_valid = vld_pipe[2];

endmodule
